adc_spi_scanner: RTL and testbench

//  Parametrised SPI master for the MIKROE-340 (MCP3204/3208-class 12-bit ADC).

---
 rtl/adc_spi_scanner_if.sv | 21 ++
 rtl/adc_spi_scanner.sv | 187 ++++++++++++++++++
 tb/tb_adc_spi_scanner.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_scanner_if.sv
// Request/result bus of the MCP3204/3208 scanner: conversion requests in, tagged results out.
interface adc_spi_scanner_if;
   logic        start;
   logic        scan_en;
   logic [2:0]  ch_sel;
   logic        diff_mode;
   logic        busy;
   logic [11:0] sample_data;
   logic [2:0]  sample_ch;
   logic        sample_valid;

   modport master (
      output start, scan_en, ch_sel, diff_mode,
      input  busy, sample_data, sample_ch, sample_valid
   );

   modport slave (
      input  start, scan_en, ch_sel, diff_mode,
      output busy, sample_data, sample_ch, sample_valid
   );
endinterface

// File: rtl/adc_spi_scanner.sv
// SPI master for an MCP3204/3208-class 12-bit ADC (MIKROE-340 pins CS/P3/P4/P5).
// Single conversions on request or round-robin scanning; SCLK is a registered
// output advanced by a divider tick, so everything stays in the clk domain.
module adc_spi_scanner #(
   parameter int CLK_DIV = 500,
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 12,
   parameter int CS_IDLE = 2
) (
   input  logic               clk,
   input  logic               rst,
   adc_spi_scanner_if.slave   bus,
   output logic               CS,
   output logic               P3,
   input  logic               P4,
   output logic               P5
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HLD_W = (CS_IDLE > 1) ? $clog2(CS_IDLE + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [HLD_W-1:0] HLD_LAST  = HLD_W'(CS_IDLE - 1);
   localparam logic [2:0]       CH_LAST   = 3'(NUM_CH - 1);
   localparam logic [4:0]       K_LAST    = 5'd18;
   localparam logic [4:0]       K_DATA0   = 5'd7;

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt;
   logic               tick;
   logic [4:0]         k, k_n, k_inc;
   logic [HLD_W-1:0]   hold, hold_n;
   logic [2:0]         ch, ch_n, ch_clamp;
   logic               diff, diff_n;
   logic [DATA_W-1:0]  sh, sh_n;
   logic [2:0]         ptr, ptr_n;
   logic               cs_q, cs_n;
   logic               p3_q, p3_n;
   logic               p5_q, p5_n, mosi_nxt;
   logic               busy_q, busy_n;
   logic [DATA_W-1:0]  sdata, sdata_n;
   logic [2:0]         sch, sch_n;
   logic               svalid, svalid_n;

   assign tick = (cnt == CNT_LAST);

   // Half-period divider: parked at zero in IDLE so every frame starts phase-aligned.
   always_ff @(posedge clk) begin
      if (rst || state == IDLE) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Frame sequencer: next state and next values of every registered output.
   always_comb begin
      state_n  = state;
      k_n      = k;
      hold_n   = hold;
      ch_n     = ch;
      diff_n   = diff;
      sh_n     = sh;
      ptr_n    = ptr;
      cs_n     = cs_q;
      p3_n     = p3_q;
      p5_n     = p5_q;
      busy_n   = busy_q;
      sdata_n  = sdata;
      sch_n    = sch;
      svalid_n = 1'b0;

      ch_clamp = ({1'b0, bus.ch_sel} >= 4'(NUM_CH)) ? CH_LAST : bus.ch_sel;
      k_inc    = k + 5'd1;
      case (k_inc)
         5'd1:    mosi_nxt = ~diff;
         5'd2:    mosi_nxt = ch[2];
         5'd3:    mosi_nxt = ch[1];
         5'd4:    mosi_nxt = ch[0];
         default: mosi_nxt = 1'b0;
      endcase

      case (state)
         IDLE: begin
            if (bus.scan_en || bus.start) begin
               ch_n    = bus.scan_en ? ptr : ch_clamp;
               diff_n  = bus.diff_mode;
               cs_n    = 1'b0;
               busy_n  = 1'b1;
               p5_n    = 1'b1;
               state_n = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               k_n     = '0;
               state_n = XFER;
            end
         end
         XFER: begin
            if (tick) begin
               if (!p3_q) begin
                  p3_n = 1'b1;
                  if (k >= K_DATA0) begin
                     sh_n = {sh[DATA_W-2:0], P4};
                  end
               end else begin
                  p3_n = 1'b0;
                  if (k == K_LAST) begin
                     cs_n     = 1'b1;
                     p5_n     = 1'b0;
                     sdata_n  = sh;
                     sch_n    = ch;
                     svalid_n = 1'b1;
                     hold_n   = '0;
                     state_n  = HOLD;
                  end else begin
                     k_n  = k_inc;
                     p5_n = mosi_nxt;
                  end
               end
            end
         end
         HOLD: begin
            if (tick) begin
               if (hold == HLD_LAST) begin
                  busy_n  = 1'b0;
                  state_n = IDLE;
                  if (bus.scan_en) begin
                     ptr_n = (ptr == CH_LAST) ? 3'd0 : ptr + 3'd1;
                  end
               end else begin
                  hold_n = hold + HLD_W'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any frame without a valid pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         k      <= '0;
         hold   <= '0;
         ch     <= '0;
         diff   <= 1'b0;
         sh     <= '0;
         ptr    <= '0;
         cs_q   <= 1'b1;
         p3_q   <= 1'b0;
         p5_q   <= 1'b0;
         busy_q <= 1'b0;
         sdata  <= '0;
         sch    <= '0;
         svalid <= 1'b0;
      end else begin
         state  <= state_n;
         k      <= k_n;
         hold   <= hold_n;
         ch     <= ch_n;
         diff   <= diff_n;
         sh     <= sh_n;
         ptr    <= ptr_n;
         cs_q   <= cs_n;
         p3_q   <= p3_n;
         p5_q   <= p5_n;
         busy_q <= busy_n;
         sdata  <= sdata_n;
         sch    <= sch_n;
         svalid <= svalid_n;
      end
   end

   assign CS               = cs_q;
   assign P3               = p3_q;
   assign P5               = p5_q;
   assign bus.busy         = busy_q;
   assign bus.sample_data  = sdata;
   assign bus.sample_ch    = sch;
   assign bus.sample_valid = svalid;

endmodule

// File: tb/tb_adc_spi_scanner.sv
// Bench for adc_spi_scanner: behavioural MCP3204 on the pins, expectation
// queue filled by the stimulus, checked by a negedge monitor.
module tb_adc_spi_scanner;

   localparam int CLK_DIV = 4;
   localparam int NUM_CH  = 4;
   localparam int CS_IDLE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic CS, P3, P4, P5;

   adc_spi_scanner_if bus();

   adc_spi_scanner #(.CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .DATA_W(12), .CS_IDLE(CS_IDLE)) dut (
      .clk(clk), .rst(rst), .bus(bus), .CS(CS), .P3(P3), .P4(P4), .P5(P5)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // expectation queue: written by stimulus (wr_ptr), consumed by monitor (rd_ptr)
   int exp_ch   [256];
   int exp_data [256];
   int exp_diff [256];
   int exp_t    [256];
   int wr_ptr = 0;
   int rd_ptr = 0;
   logic [11:0] adc_val [8];

   // monitor / ADC model state
   int n_cmp = 0;
   int n_err = 0;
   int rise_k = 0;
   int p5_bad = 0;
   int sclk_bad = 0;
   int cs_high = 0;
   logic [4:0]  cmd = '0;
   logic [11:0] cur_val = '0;
   logic cs_prev = 1'b1, p3_prev = 1'b0, rst_prev = 1'b0, after_frame = 1'b0;

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic int exp_cmd(input int c, input int d);
      return 1 + ((1 - d) << 1) + (((c >> 2) & 1) << 2) + (((c >> 1) & 1) << 3) + ((c & 1) << 4);
   endfunction

   // ADC model and result monitor, both working between clk rising edges
   always @(negedge clk) begin
      if (rst_prev) begin
         chk("rst_CS", int'(CS), 1);
         chk("rst_P3", int'(P3), 0);
         chk("rst_P5", int'(P5), 0);
         chk("rst_busy", int'(bus.busy), 0);
         chk("rst_valid", int'(bus.sample_valid), 0);
         chk("rst_data", int'(bus.sample_data), 0);
         chk("rst_ch", int'(bus.sample_ch), 0);
         rd_ptr = wr_ptr;
         after_frame = 1'b0;
         P4 = 1'b0;
      end else begin
         if (cs_prev && !CS) begin
            chk("frame_expected", int'(rd_ptr != wr_ptr), 1);
            if (after_frame) chk("cs_idle_time", int'(cs_high >= CS_IDLE * CLK_DIV), 1);
            rise_k = 0; p5_bad = 0; sclk_bad = 0; cmd = '0; P4 = 1'b0;
         end
         if (CS && !p3_prev && P3) sclk_bad++;
         if (!CS && !p3_prev && P3) begin
            if (rise_k < 5) cmd[rise_k] = P5;
            else if (P5) p5_bad++;
            rise_k++;
         end
         if (!CS && p3_prev && !P3) begin
            if (rise_k == 5) cur_val = adc_val[{cmd[2], cmd[3], cmd[4]}];
            P4 = (rise_k >= 7 && rise_k <= 18) ? cur_val[18 - rise_k] : 1'b0;
         end
         if (bus.sample_valid) begin
            chk("valid_expected", int'(rd_ptr != wr_ptr), 1);
            if (rd_ptr != wr_ptr) begin
               chk("sample_data", int'(bus.sample_data), exp_data[rd_ptr]);
               chk("sample_ch", int'(bus.sample_ch), exp_ch[rd_ptr]);
               chk("sclk_rises", rise_k, 19);
               chk("mosi_cmd", int'(cmd), exp_cmd(exp_ch[rd_ptr], exp_diff[rd_ptr]));
               chk("mosi_tail_low", p5_bad, 0);
               chk("sclk_cs_high", sclk_bad, 0);
               chk("cs_at_valid", int'(CS), 1);
               if (exp_t[rd_ptr] >= 0) chk("latency", cyc - exp_t[rd_ptr], 1 + 39 * CLK_DIV);
               rd_ptr++;
               after_frame = 1'b1;
            end
         end
         if (CS) cs_high++;
         else cs_high = 0;
      end
      cs_prev = CS; p3_prev = P3; rst_prev = rst;
   end

   function automatic int clamp(input int c);
      return (c >= NUM_CH) ? NUM_CH - 1 : c;
   endfunction

   task automatic push(input int c, input int d, input int v, input int t);
      exp_ch[wr_ptr] = c; exp_diff[wr_ptr] = d; exp_data[wr_ptr] = v; exp_t[wr_ptr] = t;
      wr_ptr++;
   endtask

   // request one conversion; mid-frame changes to ch_sel/diff_mode must not matter
   task automatic issue(input int c, input int d);
      push(clamp(c), d, int'(adc_val[clamp(c)]), cyc);
      bus.ch_sel = 3'(c); bus.diff_mode = d[0]; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.ch_sel = 3'($urandom_range(0, 7)); bus.diff_mode = 1'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         if (!bus.busy && rd_ptr == wr_ptr) return;
      end
      $display("FAIL wait_idle: timeout, busy=%0b pending=%0d", bus.busy, wr_ptr - rd_ptr);
      $fatal(1, "timeout");
   endtask

   task automatic wait_rise(input int k);
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (!CS && rise_k == k) return;
      end
      $display("FAIL wait_rise: timeout waiting for rise %0d, got %0d", k, rise_k);
      $fatal(1, "timeout");
   endtask

   initial begin
      bus.start = 1'b0; bus.scan_en = 1'b0; bus.ch_sel = '0; bus.diff_mode = 1'b0;
      for (int c = 0; c < 8; c++) adc_val[c] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // single conversion, single-ended
      adc_val[2] = 12'hA5C;
      issue(2, 0);
      wait_idle();

      // reset while idle clears the result registers
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk); #1;

      // differential, then an out-of-range channel that clamps
      adc_val[1] = 12'hFFF;
      issue(1, 1);
      wait_idle();
      adc_val[3] = 12'h000;
      issue(7, 0);
      wait_idle();

      // round-robin scan of five frames; scan_en dropped mid-way through the last
      for (int c = 0; c < 8; c++) adc_val[c] = 12'(12'h100 + c);
      for (int i = 0; i < 5; i++) push(i % NUM_CH, 0, 12'h100 + (i % NUM_CH), -1);
      bus.diff_mode = 1'b0;
      bus.scan_en = 1'b1;
      for (int i = 0; i < 3000 && rd_ptr < wr_ptr - 1; i++) begin
         @(posedge clk); #1;
      end
      if (rd_ptr < wr_ptr - 1) begin
         $display("FAIL scan_progress: timeout, pending=%0d", wr_ptr - rd_ptr);
         $fatal(1, "timeout");
      end
      wait_rise(9);
      bus.scan_en = 1'b0;
      bus.ch_sel = 3'd2; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_idle();
      repeat (200) @(posedge clk); #1;

      // reset mid-frame, then a clean frame
      adc_val[1] = 12'($urandom);
      issue(1, 0);
      wait_rise(10);
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      adc_val[2] = 12'h3C7;
      issue(2, 1);
      wait_idle();

      // randomized single conversions
      for (int i = 0; i < 10; i++) begin
         int c, d;
         c = $urandom_range(0, 7);
         d = $urandom_range(0, 1);
         adc_val[clamp(c)] = 12'($urandom);
         issue(c, d);
         wait_idle();
      end

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
